// File: rtl/pll_mon_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pll_mon_pkg
//  Description : Shared constants and helpers for the PLL clock monitor.
//                It holds the FSM state encodings, the counter-width helpers
//                and the edge-counter sizing check.
//  Revision    : 1.0 - initial release
// ============================================================================
package pll_mon_pkg;

    // FSM state encodings
    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_SETTLE  = 2'd1;
    localparam logic [1:0] c_ST_MEASURE = 2'd2;
    localparam logic [1:0] c_ST_EVAL    = 2'd3;

    // Bits needed to hold values 0..max_val (at least 1).
    function automatic int unsigned width_for(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    // The maximum number of rising edges a window can contain is
    // ceil(gate/2). True when a cnt_w-bit counter holds that count
    // without reaching its all-ones value.
    function automatic bit cnt_w_fits(input int unsigned cnt_w,
                                      input int unsigned gate);
        return (64'((gate + 1) / 2) < (64'd1 << cnt_w) - 64'd1);
    endfunction

endpackage : pll_mon_pkg
`default_nettype wire

// File: rtl/pll_clk_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module      : pll_clk_monitor_if
//  Description : Status bus of the PLL clock monitor.
//                edge_cnt  : edge count of the last completed window
//                cnt_valid : 1-cycle pulse when edge_cnt updates
//                freq_ok   : frequency qualified
//                freq_err  : 1-cycle pulse on a failed (or stuck) window
//                Modport master drives the bus and modport slave observes it.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pll_clk_monitor_if #(
    parameter int unsigned CNT_W = 16
);
    logic [CNT_W-1:0] edge_cnt;
    logic             cnt_valid;
    logic             freq_ok;
    logic             freq_err;

    modport master (output edge_cnt, output cnt_valid, output freq_ok, output freq_err);
    modport slave  (input  edge_cnt, input  cnt_valid, input  freq_ok, input  freq_err);
endinterface : pll_clk_monitor_if
`default_nettype wire

// File: rtl/pll_mon_edge_sync.sv
`default_nettype none
// ============================================================================
//  Module      : pll_mon_edge_sync
//  Description : Two-flop synchroniser with rising-edge detect.
//                clk   in  1  sampling clock
//                rst_n in  1  synchronous reset, active low
//                din   in  1  asynchronous input
//                sync  out 1  synchronised level
//                rise  out 1  high for one cycle after sync goes 0->1
//  Revision    : 1.0 - initial release
// ============================================================================
module pll_mon_edge_sync (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic din,
    output logic      sync,
    output logic      rise
);
    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= din;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign sync = r_sync;
    assign rise = r_sync & ~r_prev;
endmodule : pll_mon_edge_sync
`default_nettype wire

// File: rtl/pll_clk_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : pll_clk_monitor
//  Description : Frequency checker for the rPLL divided output. It counts
//                meas_clk rising edges over back-to-back GATE_CYCLES windows
//                and compares each count to EXP_COUNT +/- TOL. freq_ok is
//                asserted after GOOD_RUNS consecutive passing windows.
//                clk      in  1  reference clock
//                rst_n    in  1  synchronous reset, active low
//                en       in  1  monitor enable (low forces IDLE)
//                pll_lock in  1  PLL lock (asynchronous)
//                meas_clk in  1  clock under test, sampled as data
//                mon      if  master: edge_cnt/cnt_valid/freq_ok/freq_err
//                Optional macro PLL_MON_STUCK_EN: when it is defined, a
//                window with no edge for STUCK_CYCLES cycles is flagged early.
//  Revision    : 1.0 - initial release
// ============================================================================
module pll_clk_monitor
    import pll_mon_pkg::*;
#(
    parameter int unsigned GATE_CYCLES   = 27000,
    parameter int unsigned EXP_COUNT     = 9000,
    parameter int unsigned TOL           = 9,
    parameter int unsigned GOOD_RUNS     = 4,
    parameter int unsigned SETTLE_CYCLES = 2700,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned STUCK_CYCLES  = 16
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         en,
    input  wire logic         pll_lock,
    input  wire logic         meas_clk,
    pll_clk_monitor_if.master mon
);
    localparam int unsigned c_TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int unsigned c_TMR_W   = width_for(c_TMR_MAX);
    localparam int unsigned c_GOOD_W  = width_for(GOOD_RUNS);
    localparam bit          c_CNT_FITS = cnt_w_fits(CNT_W, GATE_CYCLES);

    localparam logic [c_TMR_W-1:0]  c_SETTLE_LAST = c_TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [c_TMR_W-1:0]  c_MEAS_LAST   = c_TMR_W'(GATE_CYCLES - 2);
    localparam logic [c_GOOD_W-1:0] c_GOOD_MAX    = c_GOOD_W'(GOOD_RUNS);
    localparam logic [CNT_W-1:0]    c_EXP         = CNT_W'(EXP_COUNT);
    localparam logic [CNT_W:0]      c_TOL         = (CNT_W+1)'(TOL);

    logic                w_lock_s;
    logic                w_lock_rise;
    logic                w_meas_s;
    logic                w_meas_rise;

    logic [1:0]          r_state;
    logic [c_TMR_W-1:0]  r_timer;
    logic [CNT_W-1:0]    r_cnt;
    logic [c_GOOD_W-1:0] r_good;
    logic [CNT_W-1:0]    r_edge_cnt;
    logic                r_cnt_valid;
    logic                r_freq_ok;
    logic                r_freq_err;

    logic [CNT_W-1:0]    w_cnt_next;
    logic signed [CNT_W:0] w_diff;
    logic [CNT_W:0]      w_abs;
    logic                w_pass;
    logic [c_GOOD_W-1:0] w_good_inc;
    logic                w_in_window;
    logic                w_stuck_fire;

    pll_mon_edge_sync u_meas_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (meas_clk),
        .sync  (w_meas_s),
        .rise  (w_meas_rise)
    );

    // Lock only needs the synchronised level; its edge output is not used.
    pll_mon_edge_sync u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (pll_lock),
        .sync  (w_lock_s),
        .rise  (w_lock_rise)
    );

    // A correctly sized counter cannot wrap, so the hold-at-max path is
    // only built when CNT_W is too narrow for the window.
    if (c_CNT_FITS) begin : g_cnt_plain
        assign w_cnt_next = r_cnt + CNT_W'(w_meas_rise);
    end else begin : g_cnt_sat
        assign w_cnt_next = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(w_meas_rise);
    end

    // During EVAL the last cycle's edge is folded in, so w_cnt_next is the
    // final count of the window.
    assign w_diff     = $signed({1'b0, w_cnt_next}) - $signed({1'b0, c_EXP});
    assign w_abs      = w_diff[CNT_W] ? (CNT_W+1)'(-w_diff) : (CNT_W+1)'(w_diff);
    assign w_pass     = (w_abs <= c_TOL);
    assign w_good_inc = (r_good == c_GOOD_MAX) ? r_good : r_good + c_GOOD_W'(1);

    assign w_in_window = en && w_lock_s &&
                         ((r_state == c_ST_MEASURE) || (r_state == c_ST_EVAL));

`ifdef PLL_MON_STUCK_EN
    localparam int unsigned c_STK_W = width_for(STUCK_CYCLES);
    localparam logic [c_STK_W-1:0] c_STK_LAST = c_STK_W'(STUCK_CYCLES - 1);

    logic [c_STK_W-1:0] r_stuck;

    assign w_stuck_fire = w_in_window && !w_meas_rise && (r_stuck == c_STK_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stuck <= '0;
        end else if (!w_in_window || w_meas_rise || w_stuck_fire) begin
            r_stuck <= '0;
        end else begin
            r_stuck <= r_stuck + c_STK_W'(1);
        end
    end
`else
    assign w_stuck_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_timer     <= '0;
            r_cnt       <= '0;
            r_good      <= '0;
            r_edge_cnt  <= '0;
            r_cnt_valid <= 1'b0;
            r_freq_ok   <= 1'b0;
            r_freq_err  <= 1'b0;
        end else begin
            r_cnt_valid <= 1'b0;
            r_freq_err  <= 1'b0;
            if (!en) begin
                r_state   <= c_ST_IDLE;
                r_timer   <= '0;
                r_cnt     <= '0;
                r_good    <= '0;
                r_freq_ok <= 1'b0;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        r_state <= c_ST_SETTLE;
                        r_timer <= '0;
                        r_cnt   <= '0;
                    end
                    c_ST_SETTLE: begin
                        // Settle time must be continuous lock; any dropout restarts it.
                        if (!w_lock_s) begin
                            r_timer <= '0;
                        end else if (r_timer == c_SETTLE_LAST) begin
                            r_state <= c_ST_MEASURE;
                            r_timer <= '0;
                            r_cnt   <= '0;
                        end else begin
                            r_timer <= r_timer + c_TMR_W'(1);
                        end
                    end
                    c_ST_MEASURE, c_ST_EVAL: begin
                        if (!w_lock_s) begin
                            // Lock lost: discard the partial window.
                            r_state   <= c_ST_SETTLE;
                            r_timer   <= '0;
                            r_cnt     <= '0;
                            r_good    <= '0;
                            r_freq_ok <= 1'b0;
                        end else if (w_stuck_fire) begin
                            r_state    <= c_ST_MEASURE;
                            r_timer    <= '0;
                            r_cnt      <= '0;
                            r_good     <= '0;
                            r_freq_ok  <= 1'b0;
                            r_freq_err <= 1'b1;
                        end else if (r_state == c_ST_MEASURE) begin
                            r_cnt <= w_cnt_next;
                            if (r_timer == c_MEAS_LAST) begin
                                r_state <= c_ST_EVAL;
                            end
                            r_timer <= r_timer + c_TMR_W'(1);
                        end else begin
                            // Last cycle of the window; the next one starts immediately.
                            r_edge_cnt  <= w_cnt_next;
                            r_cnt_valid <= 1'b1;
                            r_cnt       <= '0;
                            r_timer     <= '0;
                            r_state     <= c_ST_MEASURE;
                            if (w_pass) begin
                                r_good    <= w_good_inc;
                                r_freq_ok <= (w_good_inc == c_GOOD_MAX);
                            end else begin
                                r_good     <= '0;
                                r_freq_ok  <= 1'b0;
                                r_freq_err <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= c_ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign mon.edge_cnt  = r_edge_cnt;
    assign mon.cnt_valid = r_cnt_valid;
    assign mon.freq_ok   = r_freq_ok;
    assign mon.freq_err  = r_freq_err;
endmodule : pll_clk_monitor
`default_nettype wire

// File: tb/tb_pll_clk_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pll_clk_monitor
//  Description : Self-checking bench for pll_clk_monitor. A window-level
//                reference model predicts every output on every cycle.
//                Directed scenarios pin known counts and latencies, and a
//                randomised phase follows them. Honours PLL_MON_STUCK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_clk_monitor;
    localparam int GATE   = 30;
    localparam int EXP    = 10;
    localparam int TOL_P  = 1;
    localparam int GOOD   = 2;
    localparam int SETTLE = 8;
    localparam int CW     = 16;
    localparam int STUCK  = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic pll_lock = 1'b0;
    logic meas_clk = 1'b0;

    pll_clk_monitor_if #(.CNT_W(CW)) mon_if ();

    pll_clk_monitor #(
        .GATE_CYCLES(GATE), .EXP_COUNT(EXP), .TOL(TOL_P), .GOOD_RUNS(GOOD),
        .SETTLE_CYCLES(SETTLE), .CNT_W(CW), .STUCK_CYCLES(STUCK)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .pll_lock(pll_lock),
        .meas_clk(meas_clk), .mon(mon_if)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // meas_clk generator: 0 = held low, 1 = fixed period, 2 = alternating 2/4
    int meas_mode = 0;
    int meas_per = 3;
    initial begin
        int ph;
        int cur;
        ph = 0;
        cur = 3;
        forever begin
            @(negedge clk);
            if (meas_mode == 0) begin
                meas_clk = 1'b0;
                ph = 0;
            end else begin
                if (ph == 0) cur = (meas_mode == 1) ? meas_per : ((cur == 2) ? 4 : 2);
                meas_clk = (ph < cur / 2);
                ph = (ph + 1 >= cur) ? 0 : ph + 1;
            end
        end
    end

    // Reference model. The pins reach the logic two clocks late, and an
    // edge is a 0->1 step between consecutive delayed samples. The monitor
    // is idle, settling, or somewhere in a GATE-long window.
    logic [2:0] mh = '0;
    logic [2:0] lh = '0;
    int m_mode = 0;
    int m_sc = 0;
    int m_pos = 0;
    int m_cnt = 0;
    int m_good = 0;
    int m_stuck = 0;
    int m_edge = 0;
    bit m_valid = 0;
    bit m_err = 0;
    bit m_ok;

    always @(posedge clk) begin
        bit rise;
        bit lk;
        bit fire;
        int d;
        rise = mh[1] & ~mh[2];
        lk = lh[1];
        mh = {mh[1:0], meas_clk};
        lh = {lh[1:0], pll_lock};
        m_valid = 0;
        m_err = 0;
        fire = 0;
        if (!rst_n) begin
            m_mode = 0; m_sc = 0; m_pos = 0; m_cnt = 0; m_good = 0; m_stuck = 0; m_edge = 0;
        end else if (!en) begin
            m_mode = 0; m_good = 0; m_stuck = 0;
        end else if (m_mode == 0) begin
            m_mode = 1; m_sc = 0;
        end else if (m_mode == 1) begin
            if (!lk) m_sc = 0;
            else if (m_sc == SETTLE - 1) begin
                m_mode = 2; m_pos = 0; m_cnt = 0; m_stuck = 0;
            end else m_sc++;
        end else if (!lk) begin
            m_mode = 1; m_sc = 0; m_good = 0; m_stuck = 0;
        end else begin
`ifdef PLL_MON_STUCK_EN
            m_stuck = rise ? 0 : m_stuck + 1;
            if (m_stuck == STUCK) begin
                fire = 1; m_stuck = 0;
            end
`endif
            if (fire) begin
                m_err = 1; m_good = 0; m_pos = 0; m_cnt = 0;
            end else begin
                m_cnt += int'(rise);
                if (m_pos == GATE - 1) begin
                    m_edge = m_cnt;
                    m_valid = 1;
                    d = (m_cnt > EXP) ? m_cnt - EXP : EXP - m_cnt;
                    if (d <= TOL_P) m_good = (m_good < GOOD) ? m_good + 1 : GOOD;
                    else begin
                        m_good = 0; m_err = 1;
                    end
                    m_cnt = 0; m_pos = 0;
                end else m_pos++;
            end
        end
        m_ok = (m_good == GOOD);
        cyc++;
        #1;
        chk("edge_cnt", 32'(mon_if.edge_cnt), 32'(m_edge));
        chk("cnt_valid", 32'(mon_if.cnt_valid), 32'(m_valid));
        chk("freq_ok", 32'(mon_if.freq_ok), 32'(m_ok));
        chk("freq_err", 32'(mon_if.freq_err), 32'(m_err));
    end

    // Returns the number of posedges until cnt_valid is seen (-1 on timeout).
    task automatic wait_valid(input int budget, output int waited);
        waited = -1;
        for (int k = 1; k <= budget; k++) begin
            @(posedge clk); #2;
            if (mon_if.cnt_valid) begin
                waited = k;
                return;
            end
        end
        n_cmp++; n_fail++;
        $display("FAIL valid_timeout: got no cnt_valid within %0d cycles (cycle %0d)", budget, cyc);
    endtask

    task automatic wait_err(input int budget, output int waited);
        waited = -1;
        for (int k = 1; k <= budget; k++) begin
            @(posedge clk); #2;
            if (mon_if.freq_err) begin
                waited = k;
                return;
            end
        end
        n_cmp++; n_fail++;
        $display("FAIL err_timeout: got no freq_err within %0d cycles (cycle %0d)", budget, cyc);
    endtask

    initial begin
        int w;
        int nv;
        rst_n = 1'b0; en = 1'b0; pll_lock = 1'b0; meas_mode = 0;
        repeat (5) @(negedge clk);
        chk("rst_edge_cnt", 32'(mon_if.edge_cnt), 0);
        chk("rst_freq_ok", 32'(mon_if.freq_ok), 0);
        chk("rst_cnt_valid", 32'(mon_if.cnt_valid), 0);
        chk("rst_freq_err", 32'(mon_if.freq_err), 0);
        rst_n = 1'b1; en = 1'b1; pll_lock = 1'b1; meas_mode = 1; meas_per = 3;

        // Nominal period 3: 10 edges per 30-cycle window, qualified at 2nd window
        for (int i = 0; i < 4; i++) begin
            wait_valid(100, w);
            chk("p3_edge_cnt", 32'(mon_if.edge_cnt), 10);
            chk("p3_freq_err", 32'(mon_if.freq_err), 0);
            chk("p3_freq_ok", 32'(mon_if.freq_ok), (i >= 1) ? 1 : 0);
            if (i > 0) chk("p3_interval", w, 30);
        end

        // Slow clock (period 4): pure window holds 7 or 8 edges and fails
        @(negedge clk); meas_per = 4;
        wait_valid(40, w);
        wait_valid(40, w);
        chk("p4_edge_range", 32'(mon_if.edge_cnt == 7 || mon_if.edge_cnt == 8), 1);
        chk("p4_freq_err", 32'(mon_if.freq_err), 1);
        chk("p4_freq_ok", 32'(mon_if.freq_ok), 0);

        // Restore: requalified after two clean windows
        @(negedge clk); meas_per = 3;
        wait_valid(40, w);
        wait_valid(40, w);
        chk("rest_edge_cnt", 32'(mon_if.edge_cnt), 10);
        wait_valid(40, w);
        chk("rest_freq_ok", 32'(mon_if.freq_ok), 1);

        // Lock drop mid-window
        repeat (10) @(negedge clk);
        pll_lock = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("lockloss_freq_ok", 32'(mon_if.freq_ok), 0);
        nv = 0;
        for (int k = 0; k < 17; k++) begin
            @(posedge clk); #2;
            nv += int'(mon_if.cnt_valid);
        end
        chk("lockloss_no_valid", nv, 0);
        @(negedge clk); pll_lock = 1'b1;
        // 2 sync + 8 settle + 30 window cycles from the relock edge
        wait_valid(100, w);
        chk("relock_latency", w, 40);

        // en low for one clock during MEASURE
        repeat (5) @(negedge clk);
        en = 1'b0;
        @(negedge clk); en = 1'b1;
        // valid on the 39th edge counted from (and including) the re-enable edge
        wait_valid(100, w);
        chk("en_restart_latency", w, 39);
        chk("en_restart_ok", 32'(mon_if.freq_ok), 0);

        // Jitter 2/4: 9..11 edges and qualification holds
        @(negedge clk); meas_mode = 2;
        for (int i = 0; i < 5; i++) begin
            wait_valid(40, w);
            if (i >= 1) chk("jit_edge_range", 32'(mon_if.edge_cnt >= 9 && mon_if.edge_cnt <= 11), 1);
            if (i >= 2) chk("jit_freq_ok", 32'(mon_if.freq_ok), 1);
        end

        // Dead clock
        @(negedge clk); meas_mode = 0;
`ifdef PLL_MON_STUCK_EN
        wait_err(40, w);
        chk("stuck_freq_ok", 32'(mon_if.freq_ok), 0);
        nv = 0;
        for (int k = 0; k < 2; k++) begin
            wait_err(40, w);
            chk("stuck_interval", w, STUCK);
        end
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #2;
            nv += int'(mon_if.cnt_valid);
        end
        chk("stuck_no_valid", nv, 0);
`else
        wait_valid(40, w);
        wait_valid(40, w);
        chk("dead_edge_cnt", 32'(mon_if.edge_cnt), 0);
        chk("dead_freq_err", 32'(mon_if.freq_err), 1);
        chk("dead_freq_ok", 32'(mon_if.freq_ok), 0);
`endif

        // Randomised phase, checked by the model only
        for (int s = 0; s < 16; s++) begin
            @(negedge clk);
            case ($urandom_range(0, 5))
                0: meas_mode = 2;
                1: meas_mode = 0;
                default: begin meas_mode = 1; meas_per = $urandom_range(2, 6); end
            endcase
            repeat ($urandom_range(20, 90)) @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                pll_lock = 1'b0;
                repeat ($urandom_range(1, 12)) @(negedge clk);
                pll_lock = 1'b1;
            end
            if ($urandom_range(0, 4) == 0) begin
                en = 1'b0;
                repeat ($urandom_range(1, 4)) @(negedge clk);
                en = 1'b1;
            end
            meas_mode = 1; meas_per = 3;
            repeat ($urandom_range(30, 100)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule : tb_pll_clk_monitor
`default_nettype wire
